sub_pipe32: RTL and testbench
=============================

# sub_pipe32

Two-stage pipelined 32-bit subtractor computing `a - b` as `a + ~b + 1` with carry-lookahead halves. Flags: unsigned borrow, signed overflow, zero. Valid/ready handshakes on both sides give full throughput and lossless backpressure. It is the inverse-direction companion of the combinational 32-bit adder in the Toy-ALU datapath, and it feeds the ALU result mux and comparison logic.

## Interface
- No parameters; width is fixed at 32, split into two 16-bit halves.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair on `a`/`b` is valid.
- `in_ready`  out  1  block accepts the operand pair this cycle.
- `a`  in  32  minuend.
- `b`  in  32  subtrahend.
- `out_valid`  out  1  result fields are valid.
- `out_ready`  in  1  consumer accepts the result this cycle.
- `diff`  out  32  `(a - b) mod 2^32`.
- `borrow`  out  1  1 when `a < b` as unsigned values (inverted carry-out of bit 31).
- `overflow`  out  1  signed overflow: `a[31] != b[31]` and `diff[31] != a[31]`.
- `zero`  out  1  1 when `diff == 0`.

## Operation
- Stage 1 (S1) registers:
  - `d_lo = a[15:0] + ~b[15:0] + 1`.
  - Carry `c16` out of bit 15.
  - `a[31:16]`, `~b[31:16]`, `a[31]`, `b[31]`.
  - `s1_valid`.
- Stage 2 (S2) registers:
  - `diff = {a_hi + nb_hi + c16, d_lo}`.
  - `borrow = ~c32`.
  - `overflow` and `zero`.
  - `s2_valid`, which drives `out_valid`.
- Both halves are computed with 4-bit-group lookahead logic inside the block. No ripple chain is longer than 4 bits.
- Advance rules, evaluated each cycle:
  - `s2_adv = !s2_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = s1_adv`, a combinational function of state and `out_ready`.
- On an edge with `s2_adv`:
  - S2 loads from S1.
  - `s2_valid <= s1_valid`.
- On an edge with `s1_adv`:
  - S1 loads from the inputs.
  - `s1_valid <= in_valid`.
- When a stage does not advance, it holds all of its data and its valid bit.
- Output fields stay stable while `out_valid && !out_ready`.
- A simultaneous accept and deliver in one cycle is allowed; the pipeline shifts by one.
- Results leave in acceptance order. Nothing is dropped or duplicated.
- Data registers are don't-care when their valid bit is 0. They are still reset to 0 for determinism.

## Timing
- Latency: an operand pair accepted at edge k gives `out_valid = 1` in the cycle after edge k+1, i.e. 2 cycles.
- Throughput: 1 result per cycle while `out_ready = 1`.
- Capacity: 2 results in flight.
- With `out_ready` held at 0, `in_ready` drops once both stages are valid.
- `in_ready` returns to 1 in the same cycle `out_ready` rises. There is no bubble.
- Reset, on the edge where `rst = 1`:
  - `s1_valid = s2_valid = 0`.
  - `out_valid = 0`, `diff = 0`, `borrow = 0`, `overflow = 0`, `zero = 0`.
  - `in_ready` reads 1 in the cycle after reset.
- `rst` has priority over any handshake in the same cycle.
- In-flight operations are discarded. No output appears for them after reset.
- While `rst = 1`, `in_valid` is ignored.
- Wrap-around is modulo 2^32. The full 33-bit result is represented only via `borrow`.

## Test plan
- `a=5, b=3`, `out_ready=1`:
  - Response: `diff=0x00000002`, `borrow=0`, `overflow=0`, `zero=0`.
  - `out_valid` rises exactly 2 cycles after acceptance.
- `a=0, b=1`:
  - Response: `diff=0xFFFFFFFF`, `borrow=1`, `overflow=0`, `zero=0`.
- `a=0x80000000, b=1`:
  - Response: `diff=0x7FFFFFFF`, `borrow=0`, `overflow=1`.
- `a=0x00010000, b=1` (borrow crosses the 16-bit half boundary):
  - Response: `diff=0x0000FFFF`, `borrow=0`.
- `a=b=0x12345678`:
  - Response: `diff=0`, `zero=1`, `borrow=0`.
- Backpressure: `out_ready=0`, offer pairs (10,1), (20,2), (30,3) back to back.
  - Only the first two are accepted.
  - `in_ready=0` while the third is offered.
  - `diff=9` is held stable.
  - Raise `out_ready`; results arrive in the order 9, 18, 27.
  - No loss and no duplication.
- Reset mid-operation: assert `rst` for 1 cycle with 2 operations in flight.
  - `out_valid=0` and all outputs are 0 the next cycle.
  - No stale results appear afterward.
  - `in_ready=1`.

Source files
------------

// File: rtl/sub_pipe32.sv
// sub_pipe32: two-stage pipelined 32-bit subtractor (a + ~b + 1)
// with 4-bit-group lookahead halves and valid/ready on both sides.
module sub_pipe32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
  output logic        borrow,
  output logic        overflow,
  output logic        zero
);

  // Flattened 4-way lookahead: carries out of positions 0..3.
  function automatic logic [3:0] lac4(
    input logic [3:0] g,
    input logic [3:0] p,
    input logic       ci
  );
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // 16-bit add: bit lookahead in groups of 4, group lookahead on top.
  function automatic logic [16:0] cla16(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        ci
  );
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] s;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;
    logic [3:0]  gin;
    logic [3:0]  t;
    g = x & y;
    p = x ^ y;
    for (int i = 0; i < 4; i++) begin
      t     = lac4(g[4*i +: 4], p[4*i +: 4], 1'b0);
      gg[i] = t[3];
      gp[i] = &p[4*i +: 4];
    end
    gc  = lac4(gg, gp, ci);
    gin = {gc[2:0], ci};
    for (int i = 0; i < 4; i++) begin
      t = lac4(g[4*i +: 4], p[4*i +: 4], gin[i]);
      s[4*i +: 4] = p[4*i +: 4] ^ {t[2:0], gin[i]};
    end
    return {gc[3], s};
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic [15:0] d_lo_q, d_lo_d;
  logic        c16_q, c16_d;
  logic [15:0] a_hi_q, a_hi_d;
  logic [15:0] nb_hi_q, nb_hi_d;
  logic        a31_q, a31_d;
  logic        b31_q, b31_d;

  logic        s2_valid_q, s2_valid_d;
  logic [31:0] diff_q, diff_d;
  logic        borrow_q, borrow_d;
  logic        overflow_q, overflow_d;
  logic        zero_q, zero_d;

  logic        s1_adv;
  logic        s2_adv;
  logic [16:0] lo_sum;
  logic [16:0] hi_sum;
  logic [31:0] full;

  always_comb begin
    s2_adv = !s2_valid_q || out_ready;
    s1_adv = !s1_valid_q || s2_adv;
    lo_sum = cla16(a[15:0], ~b[15:0], 1'b1);
    hi_sum = cla16(a_hi_q, nb_hi_q, c16_q);
    full   = {hi_sum[15:0], d_lo_q};

    s1_valid_d = s1_valid_q;
    d_lo_d     = d_lo_q;
    c16_d      = c16_q;
    a_hi_d     = a_hi_q;
    nb_hi_d    = nb_hi_q;
    a31_d      = a31_q;
    b31_d      = b31_q;
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      d_lo_d     = lo_sum[15:0];
      c16_d      = lo_sum[16];
      a_hi_d     = a[31:16];
      nb_hi_d    = ~b[31:16];
      a31_d      = a[31];
      b31_d      = b[31];
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      diff_d     = full;
      borrow_d   = ~hi_sum[16];
      overflow_d = (a31_q != b31_q) && (full[31] != a31_q);
      zero_d     = (full == 32'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      d_lo_q     <= '0;
      c16_q      <= 1'b0;
      a_hi_q     <= '0;
      nb_hi_q    <= '0;
      a31_q      <= 1'b0;
      b31_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      d_lo_q     <= d_lo_d;
      c16_q      <= c16_d;
      a_hi_q     <= a_hi_d;
      nb_hi_q    <= nb_hi_d;
      a31_q      <= a31_d;
      b31_q      <= b31_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sub_pipe32.sv
// tb_sub_pipe32: directed vectors with hand-computed results
// for the pipelined subtractor, including backpressure and reset.
module tb_sub_pipe32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        borrow;
  logic        overflow;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  sub_pipe32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic one_op(
    input string       tag,
    input logic [31:0] va,
    input logic [31:0] vb,
    input logic [31:0] e_diff,
    input logic        e_bor,
    input logic        e_ovf,
    input logic        e_zero
  );
    a = va;
    b = vb;
    in_valid = 1'b1;
    chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, ".lat1"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".diff"}, diff, e_diff);
    chk({tag, ".borrow"}, {31'd0, borrow}, {31'd0, e_bor});
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e_ovf});
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, e_zero});
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    tick();
    tick();
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.diff", diff, 32'd0);
    chk("rst.flags", {29'd0, borrow, overflow, zero}, 32'd0);
    rst = 1'b0;
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

    one_op("sub5_3", 32'd5, 32'd3, 32'h2, 1'b0, 1'b0, 1'b0);
    one_op("sub0_1", 32'd0, 32'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    one_op("ovf_min", 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    one_op("half_x", 32'h00010000, 32'd1, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);
    one_op("eq", 32'h12345678, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b1);
    one_op("ovf_max", 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000,
           1'b1, 1'b1, 1'b0);
    one_op("max_0", 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

    // Full throughput: three back-to-back ops, one result per cycle
    in_valid = 1'b1;
    a = 32'd100; b = 32'd1;
    tick();
    a = 32'd200; b = 32'd2;
    chk("thr.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("thr.v0", {31'd0, out_valid}, 32'd1);
    chk("thr.d0", diff, 32'd99);
    a = 32'd300; b = 32'd3;
    tick();
    in_valid = 1'b0;
    chk("thr.d1", diff, 32'd198);
    tick();
    chk("thr.d2", diff, 32'd297);
    tick();
    chk("thr.drain", {31'd0, out_valid}, 32'd0);

    // Backpressure with a stalled consumer
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 32'd10; b = 32'd1;
    chk("bp.rdy0", {31'd0, in_ready}, 32'd1);
    tick();
    a = 32'd20; b = 32'd2;
    chk("bp.rdy1", {31'd0, in_ready}, 32'd1);
    tick();
    a = 32'd30; b = 32'd3;
    chk("bp.full", {31'd0, in_ready}, 32'd0);
    chk("bp.v", {31'd0, out_valid}, 32'd1);
    chk("bp.d9", diff, 32'd9);
    tick();
    chk("bp.hold_rdy", {31'd0, in_ready}, 32'd0);
    chk("bp.hold_d", diff, 32'd9);
    chk("bp.hold_v", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("bp.no_bubble", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.d18", diff, 32'd18);
    tick();
    chk("bp.d27", diff, 32'd27);
    chk("bp.v27", {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp.nodup", {31'd0, out_valid}, 32'd0);

    // Reset with two operations in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 32'd50; b = 32'd5;
    tick();
    a = 32'd60; b = 32'd6;
    tick();
    chk("mr.before", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    a = 32'd70; b = 32'd7;
    tick();
    chk("mr.valid", {31'd0, out_valid}, 32'd0);
    chk("mr.diff", diff, 32'd0);
    chk("mr.flags", {29'd0, borrow, overflow, zero}, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("mr.in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr.stale", {31'd0, out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
